// File: rtl/psram_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the QPI PSRAM responder.
package psram_pkg;

  localparam logic [7:0] CMD_RSTEN    = 8'h66;
  localparam logic [7:0] CMD_RST      = 8'h99;
  localparam logic [7:0] CMD_SPI2QPI  = 8'h35;
  localparam logic [7:0] CMD_READ     = 8'hEB;
  localparam logic [7:0] CMD_WRITE    = 8'h02;
  localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 6;
  localparam int unsigned CNT_W               = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } state_e;

endpackage

// File: rtl/psram_resp_mem.sv
// Backing store for the responder: one write port, one registered read port.
module psram_resp_mem #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              mem_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [15:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [15:0]       rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [15:0] mem_q [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge mem_clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/psram_qpi_responder.sv
// Device-side QPI PSRAM model: SPI init, QPI READ/WRITE over a small array.
// Optional: define PSRAM_RESP_QPI_EXIT_EN to accept QPI opcode F5h (exit QPI on CE rise).
module psram_qpi_responder
  import psram_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic       mem_clk,
  input  logic       rst_n,
  input  logic       mem_ce,
  input  logic [3:0] mem_sio_in,
  output logic [3:0] mem_sio_out,
  output logic       mem_sio_oe,
  output logic       qpi_mode,
  output logic       rst_armed,
  output logic       cmd_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [11:0]       wsh_q, wsh_d;
  logic [11:0]       rword_q, rword_d;
  logic [3:0]        sio_out_q, sio_out_d;
  logic              oe_q, oe_d;
  logic              qpi_q, qpi_d;
  logic              armed_q, armed_d;
  logic              err_q, err_d;
`ifdef PSRAM_RESP_QPI_EXIT_EN
  logic              exit_pend_q, exit_pend_d;
`endif

  logic [7:0]  opcode_c;
  logic        mem_we_c;
  logic [15:0] mem_wdata_c;
  logic [15:0] rd_data;

  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .mem_clk (mem_clk),
    .we      (mem_we_c),
    .waddr   (addr_q),
    .wdata   (mem_wdata_c),
    .raddr   (addr_q),
    .rdata   (rd_data)
  );

  // Next-state, datapath and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wsh_d       = wsh_q;
    rword_d     = rword_q;
    sio_out_d   = sio_out_q;
    oe_d        = oe_q;
    qpi_d       = qpi_q;
    armed_d     = armed_q;
    err_d       = 1'b0;
`ifdef PSRAM_RESP_QPI_EXIT_EN
    exit_pend_d = exit_pend_q;
`endif
    mem_we_c    = 1'b0;
    mem_wdata_c = {wsh_q, mem_sio_in};
    opcode_c    = qpi_q ? {cmd_q[3:0], mem_sio_in} : {cmd_q[6:0], mem_sio_in[0]};

    // The 4th write nibble commits even if CE rises on the same edge.
    if (state_q == S_WDATA && cnt_q == CNT_W'(3)) begin
      mem_we_c = 1'b1;
      addr_d   = addr_q + ADDR_W'(1);
    end

    if (mem_ce) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      oe_d    = 1'b0;
`ifdef PSRAM_RESP_QPI_EXIT_EN
      if (exit_pend_q) begin
        qpi_d = 1'b0;
      end
      exit_pend_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_d   = qpi_q ? {4'h0, mem_sio_in} : {7'h00, mem_sio_in[0]};
          cnt_d   = CNT_W'(1);
          state_d = S_CMD;
        end
        S_CMD: begin
          if (qpi_q) begin
            cnt_d = '0;
            case (opcode_c)
              CMD_READ, CMD_WRITE: begin
                cmd_d   = opcode_c;
                state_d = S_ADDR;
              end
`ifdef PSRAM_RESP_QPI_EXIT_EN
              CMD_QPI_EXIT: begin
                exit_pend_d = 1'b1;
                state_d     = S_IGNORE;
              end
`endif
              default: begin
                err_d   = 1'b1;
                state_d = S_IGNORE;
              end
            endcase
          end else begin
            cmd_d = opcode_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              state_d = S_IGNORE;
              case (opcode_c)
                CMD_RSTEN: armed_d = 1'b1;
                CMD_RST: begin
                  if (armed_q) begin
                    qpi_d   = 1'b0;
                    armed_d = 1'b0;
                  end
                end
                CMD_SPI2QPI: begin
                  qpi_d   = 1'b1;
                  armed_d = 1'b0;
                end
                default: begin
                  err_d   = 1'b1;
                  armed_d = 1'b0;
                end
              endcase
            end
          end
        end
        S_ADDR: begin
          // Only the low ADDR_W bits survive, so upper address bits alias.
          addr_d = ADDR_W'({addr_q, mem_sio_in});
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(5)) begin
            cnt_d   = '0;
            state_d = (cmd_q == CMD_READ) ? S_WAIT : S_WDATA;
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
            state_d   = S_RDATA;
            oe_d      = 1'b1;
            sio_out_d = rd_data[15:12];
            rword_d   = rd_data[11:0];
            addr_d    = addr_q + ADDR_W'(1);
            cnt_d     = CNT_W'(1);
          end
        end
        S_RDATA: begin
          cnt_d = (cnt_q == CNT_W'(3)) ? '0 : cnt_q + CNT_W'(1);
          case (cnt_q)
            CNT_W'(0): begin
              // Next word was prefetched from the already-incremented address.
              sio_out_d = rd_data[15:12];
              rword_d   = rd_data[11:0];
              addr_d    = addr_q + ADDR_W'(1);
            end
            CNT_W'(1): sio_out_d = rword_q[11:8];
            CNT_W'(2): sio_out_d = rword_q[7:4];
            default:   sio_out_d = rword_q[3:0];
          endcase
        end
        S_WDATA: begin
          wsh_d = {wsh_q[7:0], mem_sio_in};
          cnt_d = (cnt_q == CNT_W'(3)) ? '0 : cnt_q + CNT_W'(1);
        end
        S_IGNORE: begin
          state_d = S_IGNORE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge mem_clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wsh_q       <= '0;
      rword_q     <= '0;
      sio_out_q   <= '0;
      oe_q        <= 1'b0;
      qpi_q       <= 1'b0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
`ifdef PSRAM_RESP_QPI_EXIT_EN
      exit_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wsh_q       <= wsh_d;
      rword_q     <= rword_d;
      sio_out_q   <= sio_out_d;
      oe_q        <= oe_d;
      qpi_q       <= qpi_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
`ifdef PSRAM_RESP_QPI_EXIT_EN
      exit_pend_q <= exit_pend_d;
`endif
    end
  end

  assign mem_sio_out = sio_out_q;
  assign mem_sio_oe  = oe_q;
  assign qpi_mode    = qpi_q;
  assign rst_armed   = armed_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder with a read-nibble scoreboard.
module tb_psram_qpi_responder;

  localparam int unsigned WAIT = 6;

  logic       mem_clk;
  logic       rst_n;
  logic       mem_ce;
  logic [3:0] mem_sio_in;
  logic [3:0] mem_sio_out;
  logic       mem_sio_oe;
  logic       qpi_mode;
  logic       rst_armed;
  logic       cmd_err;

  int checks = 0;
  int errors = 0;

  logic [3:0]  exp_q [$];
  logic [15:0] mdl [256];

  psram_qpi_responder #(.ADDR_W(8), .WAIT_CYCLES(WAIT)) dut (
    .mem_clk     (mem_clk),
    .rst_n       (rst_n),
    .mem_ce      (mem_ce),
    .mem_sio_in  (mem_sio_in),
    .mem_sio_out (mem_sio_out),
    .mem_sio_oe  (mem_sio_oe),
    .qpi_mode    (qpi_mode),
    .rst_armed   (rst_armed),
    .cmd_err     (cmd_err)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, take the edge, then pop the scoreboard if the DUT drives.
  task automatic step(input logic ce, input logic [3:0] sio);
    logic [3:0] e;
    mem_ce     = ce;
    mem_sio_in = sio;
    @(posedge mem_clk);
    #1;
    if (mem_sio_oe === 1'b1) begin
      chk("rd_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_nibble", 32'(mem_sio_out), 32'(e));
      end
    end
  endtask

  task automatic spi_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) step(1'b0, {3'b000, b[i]});
  endtask

  task automatic send_byte(input logic [7:0] b);
    step(1'b0, b[7:4]);
    step(1'b0, b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) step(1'b0, 4'(a >> (4 * i)));
  endtask

  task automatic send_word(input logic [15:0] d);
    for (int i = 3; i >= 0; i--) step(1'b0, 4'(d >> (4 * i)));
  endtask

  task automatic qpi_write(input logic [23:0] a, input logic [15:0] d0,
                           input logic [15:0] d1, input int nw);
    send_byte(8'h02);
    send_addr(a);
    send_word(d0);
    mdl[a[7:0]] = d0;
    if (nw > 1) begin
      send_word(d1);
      mdl[8'(a[7:0] + 8'd1)] = d1;
    end
    step(1'b1, 4'h0);
  endtask

  // Read nnib nibbles; expectations come from the bench model.
  task automatic qpi_read(input logic [23:0] a, input int nnib);
    logic [15:0] w;
    send_byte(8'hEB);
    send_addr(a);
    for (int i = 0; i < int'(WAIT) - 1; i++) step(1'b0, 4'h0);
    for (int i = 0; i < nnib; i++) begin
      w = mdl[8'(a[7:0] + 8'(i / 4))];
      exp_q.push_back(4'(w >> (12 - 4 * (i % 4))));
    end
    for (int i = 0; i < nnib; i++) step(1'b0, 4'h0);
    step(1'b1, 4'h0);
    chk("oe_drop", 32'(mem_sio_oe), 32'd0);
    chk("rd_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_ce     = 1'b1;
    mem_sio_in = 4'h0;
    for (int i = 0; i < 3; i++) step(1'b1, 4'h0);
    chk("rst_qpi", 32'(qpi_mode), 32'd0);
    chk("rst_armed", 32'(rst_armed), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    chk("rst_oe", 32'(mem_sio_oe), 32'd0);
    chk("rst_out", 32'(mem_sio_out), 32'd0);
    rst_n = 1'b1;
    step(1'b1, 4'h0);

    // SPI 99h without RSTEN: silently ignored
    spi_bits(8'h99);
    chk("rst_alone_err", 32'(cmd_err), 32'd0);
    chk("rst_alone_qpi", 32'(qpi_mode), 32'd0);
    step(1'b1, 4'h0);

    spi_bits(8'h66);
    chk("rsten_armed", 32'(rst_armed), 32'd1);
    step(1'b1, 4'h0);
    spi_bits(8'h99);
    chk("rst_disarm", 32'(rst_armed), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    step(1'b1, 4'h0);

    // Unknown SPI opcode pulses cmd_err and disarms
    spi_bits(8'h66);
    step(1'b1, 4'h0);
    spi_bits(8'hAA);
    chk("spi_unk_err", 32'(cmd_err), 32'd1);
    chk("spi_unk_armed", 32'(rst_armed), 32'd0);
    step(1'b1, 4'h0);
    chk("spi_unk_pulse", 32'(cmd_err), 32'd0);

    spi_bits(8'h66);
    step(1'b1, 4'h0);
    spi_bits(8'h35);
    chk("spi2qpi_mode", 32'(qpi_mode), 32'd1);
    chk("spi2qpi_armed", 32'(rst_armed), 32'd0);
    chk("spi2qpi_err", 32'(cmd_err), 32'd0);
    step(1'b1, 4'h0);

    // In QPI mode 66h/99h are unknown QPI opcodes
    send_byte(8'h66);
    chk("qpi66_err", 32'(cmd_err), 32'd1);
    step(1'b0, 4'h0);
    chk("qpi66_pulse", 32'(cmd_err), 32'd0);
    step(1'b1, 4'h0);
    send_byte(8'h99);
    step(1'b1, 4'h0);
    chk("qpi99_mode", 32'(qpi_mode), 32'd1);
    chk("qpi99_armed", 32'(rst_armed), 32'd0);

    qpi_write(24'h000012, 16'hA5C3, 16'h0000, 1);
    qpi_read(24'h000012, 4);

    // Burst wrapping past the top of the array
    qpi_write(24'h0000FF, 16'h1111, 16'h2222, 2);
    qpi_read(24'h0000FF, 8);
    qpi_read(24'h000000, 4);

    // Aborted write leaves the old word; aborted read releases the bus
    qpi_write(24'h000020, 16'h7E7E, 16'h0000, 1);
    send_byte(8'h02);
    send_addr(24'h000020);
    step(1'b0, 4'h1);
    step(1'b0, 4'h2);
    step(1'b1, 4'h0);
    qpi_read(24'h000020, 4);
    qpi_read(24'h000020, 2);

    // CE rising with the 4th nibble still commits the word
    send_byte(8'h02);
    send_addr(24'h000030);
    step(1'b0, 4'hB);
    step(1'b0, 4'hE);
    step(1'b0, 4'hE);
    step(1'b1, 4'hF);
    mdl[8'h30] = 16'hBEEF;
    step(1'b1, 4'h0);
    qpi_read(24'h000030, 4);

    // Upper address bits alias
    qpi_write(24'h123440, 16'h0F0F, 16'h0000, 1);
    qpi_read(24'h000040, 4);
    qpi_read(24'hABCD40, 4);

    send_byte(8'hF5);
`ifdef PSRAM_RESP_QPI_EXIT_EN
    chk("exit_err", 32'(cmd_err), 32'd0);
    step(1'b1, 4'h0);
    chk("exit_mode", 32'(qpi_mode), 32'd0);
`else
    chk("f5_err", 32'(cmd_err), 32'd1);
    step(1'b1, 4'h0);
    chk("f5_mode", 32'(qpi_mode), 32'd1);
`endif
    step(1'b1, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
